dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
Data-memory access controller between two requesters and the single-port data SRAM: the CPU M-stage load/store port and a DMA/debug port.
- Arbitrates the two requesters round-robin and runs one transaction at a time through a fixed-latency synchronous memory.
- Converts sub-word stores into byte-enables and lane-shifted write data.
- Extracts and sign/zero-extends load data.
- Flags misaligned, out-of-range or illegal accesses without touching memory.

Parameters:
ADDR_W, 15, byte-address bits decoded; memory holds 2^ADDR_W bytes.
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..7.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  CPU request accepted this cycle
cpu_req_we  in  1  1 = store, 0 = load
cpu_req_type  in  3  DM type code (w/h/hu/b/bu)
cpu_req_addr  in  32  byte address
cpu_req_wdata  in  32  store data, right-aligned
cpu_resp_valid  out  1  one-cycle response pulse
cpu_resp_rdata  out  32  extended load data; 0 for stores and errors
cpu_resp_err  out  1  access fault, qualified by resp_valid
dma_req_valid, dma_req_ready, dma_req_we, dma_req_type, dma_req_addr, dma_req_wdata, dma_resp_valid, dma_resp_rdata, dma_resp_err: same directions, widths and meanings as the cpu_ signals
mem_en  out  1  memory access strobe
mem_be  out  4  byte write enables; 0000 for reads
mem_addr  out  ADDR_W-2  word address
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  read word, valid MEM_LAT cycles after mem_en

Behaviour:
- Clocking and reset: clk is the clock; reset is synchronous, active-high.
- Reset values: state=IDLE, rr_ptr=CPU, every output 0.
- State machine: IDLE -> ISSUE -> (WAIT if read) -> RESP -> IDLE.
  - Error path: IDLE -> RESP directly.
- IDLE
  - req_ready is combinational: asserted only toward the granted requester, and only in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the side named by rr_ptr; rr_ptr flips to the other side on every accepted request.
  - On handshake at cycle T, register we, type, addr, wdata and the owner.
- Error check at acceptance (registered). err is set if any of:
  - addr >= 2^ADDR_W;
  - h/hu with addr[0]=1;
  - w with addr[1:0]!=0;
  - store with type hu or bu;
  - undefined type code.
  On error: no mem_en ever; owner resp_valid=1, err=1, rdata=0 at T+1.
- ISSUE (T+1)
  - mem_en=1 for exactly one cycle.
  - mem_addr = addr[ADDR_W-1:2].
  - Store w: be=1111, wdata passed through.
  - Store h: be=0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - Store b: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Store: next state RESP, so resp_valid at T+2.
- WAIT (reads)
  - A counter loads MEM_LAT-1 and decrements to 0.
  - On the cycle mem_rdata is valid (T+1+MEM_LAT), capture the formatted data.
  - resp_valid at T+2+MEM_LAT.
- Load formatting:
  - w: whole word.
  - h/hu: half selected by addr[1], sign/zero-extended from bit 15.
  - b/bu: byte selected by addr[1:0], sign/zero-extended from bit 7.
- RESP
  - The owner's resp_valid pulses 1 cycle; the other side's resp stays 0; rdata/err hold their values only during the pulse.
  - Next state is IDLE; a new grant is possible in the cycle after RESP.
- Requester obligations: hold req_* stable while valid && !ready.
  - The controller never drops an un-accepted request.
  - No response without a prior handshake.
- Reset mid-transaction: the in-flight access is abandoned; no response is issued.
  - mem_en and resp_valid are 0 in the reset cycle and the cycle after.
  - rr_ptr returns to CPU.
- Throughput: one transaction per 3 cycles (store) or 3+MEM_LAT cycles (load); no pipelining of requests.

Decomposition:
- Shared constants package:
  - DM type codes DM_W=3'd0, DM_H=3'd1, DM_HU=3'd2, DM_B=3'd3, DM_BU=3'd4.
  - State encoding IDLE/ISSUE/WAIT/RESP.
  - Requester IDs CPU=0, DMA=1.
- One natural sub-module: dm_lane_fmt, combinational. It generates store byte-enables and write data, extends load data, and detects faults. It is shared by the issue and capture paths.

Test Plan:
- CPU store w 0x12345678 at 0x10 (MEM_LAT=1), then load w at 0x10 -> mem_be=1111, mem_addr=4 at T+1; load resp_valid at T+3 with rdata=0x12345678, err=0.
- Store b 0x80 at 0x13, then load b 0x13 and bu 0x13 -> mem_be=1000, mem_wdata=0x80808080; rdata=0xFFFFFF80 and 0x00000080 respectively.
- Load h at 0x11 -> no mem_en; cpu_resp_valid=1 with err=1, rdata=0 at T+1. Store hu at 0x10 -> same fault behaviour.
- CPU and DMA valid in the same cycle, continuously, for 4 transactions after reset -> grant order CPU, DMA, CPU, DMA; each resp_valid is seen only on the owner's port.
- MEM_LAT=3, load w at 0x7FFC -> resp at T+5; load at 0x8000 -> err (ADDR_W=15).
- Assert reset during WAIT of a DMA load -> no dma_resp_valid; the next CPU request is granted first and completes normally.

Source files
------------

// File: rtl/dm_access_ctrl_pkg.sv
// Shared constants for the data-memory access controller: DM type codes,
// controller states, requester IDs and the latched request record.
package dm_access_ctrl_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    typedef enum logic {
        ReqCpu = 1'b0,
        ReqDma = 1'b1
    } req_id_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  dm_type;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

endpackage

// File: rtl/dm_access_ctrl_lane_fmt.sv
// Byte-lane formatter: store byte-enables/replicated write data, load
// extraction with sign/zero extension, and access-fault detection.
module dm_lane_fmt
    import dm_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic        we,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        fault
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic        is_w, is_half, is_byte, is_unsigned;
    logic        out_of_range;

    assign half_sel    = addr[1] ? rdata[31:16] : rdata[15:0];
    assign byte_sel    = rdata[{addr[1:0], 3'b000} +: 8];
    assign is_w        = (dm_type == DM_W);
    assign is_half     = (dm_type == DM_H) || (dm_type == DM_HU);
    assign is_byte     = (dm_type == DM_B) || (dm_type == DM_BU);
    assign is_unsigned = (dm_type == DM_HU) || (dm_type == DM_BU);

    // Any address bit at or above ADDR_W lies outside the memory.
    assign out_of_range = |(addr >> ADDR_W);

    assign fault = out_of_range
                 || (dm_type > DM_BU)
                 || (is_half && addr[0])
                 || (is_w && (addr[1:0] != 2'b00))
                 || (we && is_unsigned);

    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata;
        load_data  = rdata;
        if (is_half) begin
            be         = 4'b0011 << {addr[1], 1'b0};
            lane_wdata = {2{wdata[15:0]}};
            load_data  = {{16{half_sel[15] && (dm_type == DM_H)}}, half_sel};
        end else if (is_byte) begin
            be         = 4'b0001 << addr[1:0];
            lane_wdata = {4{wdata[7:0]}};
            load_data  = {{24{byte_sel[7] && (dm_type == DM_B)}}, byte_sel};
        end else if (is_w) begin
            be = 4'b1111;
        end
        if (!we) begin
            be = 4'b0000;
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: round-robin arbitration of CPU and DMA
// requesters onto a fixed-latency single-port SRAM, one transaction at a time.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [2:0]        cpu_req_type,
    input  logic [31:0]       cpu_req_addr,
    input  logic [31:0]       cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [31:0]       cpu_resp_rdata,
    output logic              cpu_resp_err,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_we,
    input  logic [2:0]        dma_req_type,
    input  logic [31:0]       dma_req_addr,
    input  logic [31:0]       dma_req_wdata,
    output logic              dma_resp_valid,
    output logic [31:0]       dma_resp_rdata,
    output logic              dma_resp_err,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_e      state_q, state_d;
    req_id_e     rr_q, rr_d, owner_q, owner_d;
    dm_req_t     req_q, req_d, in_req, fmt_req;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        grant_dma, idle_ok, accept, issue, resp;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata, fmt_load;
    logic        fmt_fault;

    assign grant_dma = dma_req_valid && (!cpu_req_valid || (rr_q == ReqDma));
    assign in_req    = grant_dma
                     ? '{we: dma_req_we, dm_type: dma_req_type, addr: dma_req_addr,
                         wdata: dma_req_wdata}
                     : '{we: cpu_req_we, dm_type: cpu_req_type, addr: cpu_req_addr,
                         wdata: cpu_req_wdata};

    assign idle_ok       = (state_q == StIdle) && !reset;
    assign cpu_req_ready = idle_ok && cpu_req_valid && !grant_dma;
    assign dma_req_ready = idle_ok && grant_dma;
    assign accept        = cpu_req_ready || dma_req_ready;

    // One formatter serves the fault check in IDLE and the issue/capture paths later.
    assign fmt_req = (state_q == StIdle) ? in_req : req_q;

    dm_lane_fmt #(
        .ADDR_W(ADDR_W)
    ) u_lane_fmt (
        .we         (fmt_req.we),
        .dm_type    (fmt_req.dm_type),
        .addr       (fmt_req.addr),
        .wdata      (fmt_req.wdata),
        .rdata      (mem_rdata),
        .be         (fmt_be),
        .lane_wdata (fmt_wdata),
        .load_data  (fmt_load),
        .fault      (fmt_fault)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_d   = in_req;
                    owner_d = grant_dma ? ReqDma : ReqCpu;
                    rr_d    = grant_dma ? ReqCpu : ReqDma;
                    err_d   = fmt_fault;
                    rdata_d = '0;
                    state_d = fmt_fault ? StResp : StIssue;
                end
            end
            StIssue: begin
                if (req_q.we) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = fmt_load;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rr_q    <= ReqCpu;
            owner_q <= ReqCpu;
            req_q   <= '0;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by reset so an abandoned access emits nothing in the reset cycle.
    assign issue = (state_q == StIssue) && !reset;
    assign resp  = (state_q == StResp) && !reset;

    assign mem_en    = issue;
    assign mem_be    = issue ? fmt_be : 4'b0000;
    assign mem_addr  = issue ? req_q.addr[ADDR_W-1:2] : '0;
    assign mem_wdata = issue ? fmt_wdata : '0;

    assign cpu_resp_valid = resp && (owner_q == ReqCpu);
    assign cpu_resp_rdata = cpu_resp_valid ? rdata_q : '0;
    assign cpu_resp_err   = cpu_resp_valid && err_q;
    assign dma_resp_valid = resp && (owner_q == ReqDma);
    assign dma_resp_rdata = dma_resp_valid ? rdata_q : '0;
    assign dma_resp_err   = dma_resp_valid && err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench: MEM_LAT=1 instance (a_*) for the main sequence and a
// MEM_LAT=3 instance (b_*) for latency and address-range checks.
module tb_dm_access_ctrl;
    import dm_access_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_cpu_req_valid, a_cpu_req_ready, a_cpu_req_we;
    logic [2:0]  a_cpu_req_type;
    logic [31:0] a_cpu_req_addr, a_cpu_req_wdata, a_cpu_resp_rdata;
    logic        a_cpu_resp_valid, a_cpu_resp_err;
    logic        a_dma_req_valid, a_dma_req_ready, a_dma_req_we;
    logic [2:0]  a_dma_req_type;
    logic [31:0] a_dma_req_addr, a_dma_req_wdata, a_dma_resp_rdata;
    logic        a_dma_resp_valid, a_dma_resp_err;
    logic        a_mem_en;
    logic [3:0]  a_mem_be;
    logic [12:0] a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata;

    logic        b_cpu_req_valid, b_cpu_req_ready, b_cpu_req_we;
    logic [2:0]  b_cpu_req_type;
    logic [31:0] b_cpu_req_addr, b_cpu_req_wdata, b_cpu_resp_rdata;
    logic        b_cpu_resp_valid, b_cpu_resp_err;
    logic        b_dma_req_ready, b_dma_resp_valid, b_dma_resp_err;
    logic [31:0] b_dma_resp_rdata;
    logic        b_mem_en;
    logic [3:0]  b_mem_be;
    logic [12:0] b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    dm_access_ctrl #(.ADDR_W(15), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .cpu_req_valid(a_cpu_req_valid), .cpu_req_ready(a_cpu_req_ready),
        .cpu_req_we(a_cpu_req_we), .cpu_req_type(a_cpu_req_type),
        .cpu_req_addr(a_cpu_req_addr), .cpu_req_wdata(a_cpu_req_wdata),
        .cpu_resp_valid(a_cpu_resp_valid), .cpu_resp_rdata(a_cpu_resp_rdata),
        .cpu_resp_err(a_cpu_resp_err),
        .dma_req_valid(a_dma_req_valid), .dma_req_ready(a_dma_req_ready),
        .dma_req_we(a_dma_req_we), .dma_req_type(a_dma_req_type),
        .dma_req_addr(a_dma_req_addr), .dma_req_wdata(a_dma_req_wdata),
        .dma_resp_valid(a_dma_resp_valid), .dma_resp_rdata(a_dma_resp_rdata),
        .dma_resp_err(a_dma_resp_err),
        .mem_en(a_mem_en), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    dm_access_ctrl #(.ADDR_W(15), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .cpu_req_valid(b_cpu_req_valid), .cpu_req_ready(b_cpu_req_ready),
        .cpu_req_we(b_cpu_req_we), .cpu_req_type(b_cpu_req_type),
        .cpu_req_addr(b_cpu_req_addr), .cpu_req_wdata(b_cpu_req_wdata),
        .cpu_resp_valid(b_cpu_resp_valid), .cpu_resp_rdata(b_cpu_resp_rdata),
        .cpu_resp_err(b_cpu_resp_err),
        .dma_req_valid(1'b0), .dma_req_ready(b_dma_req_ready),
        .dma_req_we(1'b0), .dma_req_type(3'd0),
        .dma_req_addr(32'd0), .dma_req_wdata(32'd0),
        .dma_resp_valid(b_dma_resp_valid), .dma_resp_rdata(b_dma_resp_rdata),
        .dma_resp_err(b_dma_resp_err),
        .mem_en(b_mem_en), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // SRAM model for instance a: byte-writable words, one-cycle read latency.
    logic [31:0] a_mem [8192];
    always @(posedge clk) begin
        if (a_mem_en) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mem_be[i]) a_mem[a_mem_addr][8*i +: 8] <= a_mem_wdata[8*i +: 8];
            end
            a_mem_rdata <= a_mem[a_mem_addr];
        end
    end

    // Read-only model for instance b: three-stage read pipeline, one known word.
    logic [31:0] b_pipe [3];
    always @(posedge clk) begin
        b_pipe[0] <= (b_mem_en && (b_mem_addr == 13'h1FFF)) ? 32'hCAFE_F00D : 32'h0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_rdata = b_pipe[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a CPU request on instance a at cycle T, confirm the handshake, advance to T+1.
    task automatic a_cpu_txn(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag);
        a_cpu_req_valid = 1'b1;
        a_cpu_req_we    = we;
        a_cpu_req_type  = typ;
        a_cpu_req_addr  = addr;
        a_cpu_req_wdata = wdata;
        #1;
        check({tag, " ready"}, a_cpu_req_ready, 1);
        step();
        a_cpu_req_valid = 1'b0;
    endtask

    task automatic a_cpu_load(input logic [2:0] typ, input logic [31:0] addr,
                              input logic [31:0] exp, input string tag);
        a_cpu_txn(1'b0, typ, addr, 32'h0, tag);
        check({tag, " mem_en"}, a_mem_en, 1);
        check({tag, " mem_be"}, a_mem_be, 4'b0000);
        step();
        check({tag, " early resp"}, a_cpu_resp_valid, 0);
        step();
        check({tag, " resp_valid"}, a_cpu_resp_valid, 1);
        check({tag, " rdata"}, a_cpu_resp_rdata, exp);
        check({tag, " err"}, a_cpu_resp_err, 0);
        step();
    endtask

    task automatic a_cpu_fault(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                               input string tag);
        a_cpu_txn(we, typ, addr, 32'hFFFF_FFFF, tag);
        check({tag, " mem_en"}, a_mem_en, 0);
        check({tag, " resp_valid"}, a_cpu_resp_valid, 1);
        check({tag, " err"}, a_cpu_resp_err, 1);
        check({tag, " rdata"}, a_cpu_resp_rdata, 32'h0);
        step();
        check({tag, " after mem_en"}, a_mem_en, 0);
        check({tag, " after resp"}, a_cpu_resp_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        a_cpu_req_valid = 1'b0; a_cpu_req_we = 1'b0; a_cpu_req_type = DM_W;
        a_cpu_req_addr = '0; a_cpu_req_wdata = '0;
        a_dma_req_valid = 1'b0; a_dma_req_we = 1'b0; a_dma_req_type = DM_W;
        a_dma_req_addr = '0; a_dma_req_wdata = '0;
        b_cpu_req_valid = 1'b0; b_cpu_req_we = 1'b0; b_cpu_req_type = DM_W;
        b_cpu_req_addr = '0; b_cpu_req_wdata = '0;
        repeat (3) step();
        check("rst mem_en", a_mem_en, 0);
        check("rst cpu_resp", a_cpu_resp_valid, 0);
        check("rst dma_resp", a_dma_resp_valid, 0);
        reset = 1'b0;
        step();
        check("idle cpu_ready", a_cpu_req_ready, 0);
        check("idle mem_addr", a_mem_addr, 13'h0);

        // Store word, then read it back.
        a_cpu_txn(1'b1, DM_W, 32'h10, 32'h1234_5678, "st_w");
        check("st_w mem_en", a_mem_en, 1);
        check("st_w mem_be", a_mem_be, 4'b1111);
        check("st_w mem_addr", a_mem_addr, 13'd4);
        check("st_w mem_wdata", a_mem_wdata, 32'h1234_5678);
        step();
        check("st_w resp", a_cpu_resp_valid, 1);
        check("st_w rdata", a_cpu_resp_rdata, 32'h0);
        check("st_w err", a_cpu_resp_err, 0);
        check("st_w dma quiet", a_dma_resp_valid, 0);
        step();
        check("st_w resp pulse", a_cpu_resp_valid, 0);
        a_cpu_load(DM_W, 32'h10, 32'h1234_5678, "ld_w");

        // Byte store into lane 3, then signed/unsigned byte and half loads.
        a_cpu_txn(1'b1, DM_B, 32'h13, 32'h0000_0080, "st_b");
        check("st_b mem_be", a_mem_be, 4'b1000);
        check("st_b mem_wdata", a_mem_wdata, 32'h8080_8080);
        step();
        check("st_b resp", a_cpu_resp_valid, 1);
        step();
        a_cpu_load(DM_B, 32'h13, 32'hFFFF_FF80, "ld_b");
        a_cpu_load(DM_BU, 32'h13, 32'h0000_0080, "ld_bu");
        a_cpu_load(DM_H, 32'h12, 32'hFFFF_8034, "ld_h");
        a_cpu_load(DM_HU, 32'h12, 32'h0000_8034, "ld_hu");
        a_cpu_load(DM_B, 32'h11, 32'h0000_0056, "ld_b1");

        // Half store into upper lanes.
        a_cpu_txn(1'b1, DM_H, 32'h12, 32'hABCD_1234, "st_h");
        check("st_h mem_be", a_mem_be, 4'b1100);
        check("st_h mem_wdata", a_mem_wdata, 32'h1234_1234);
        step();
        step();
        a_cpu_load(DM_W, 32'h10, 32'h1234_5678, "ld_w2");

        // Faults: misaligned half/word, store unsigned type, undefined type.
        a_cpu_fault(1'b0, DM_H, 32'h11, "flt_h");
        a_cpu_fault(1'b1, DM_HU, 32'h10, "flt_st_hu");
        a_cpu_fault(1'b0, DM_W, 32'h12, "flt_w");
        a_cpu_fault(1'b0, 3'd5, 32'h10, "flt_type");

        // Round-robin with both sides continuously requesting, from reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_cpu_req_valid = 1'b1; a_cpu_req_we = 1'b1; a_cpu_req_type = DM_W;
        a_cpu_req_addr = 32'h20; a_cpu_req_wdata = 32'hC0C0_C0C0;
        a_dma_req_valid = 1'b1; a_dma_req_we = 1'b1; a_dma_req_type = DM_W;
        a_dma_req_addr = 32'h24; a_dma_req_wdata = 32'hD0D0_D0D0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr cpu_ready", a_cpu_req_ready, (k % 2 == 0) ? 1 : 0);
            check("rr dma_ready", a_dma_req_ready, (k % 2 == 1) ? 1 : 0);
            step();
            check("rr mem_addr", a_mem_addr, (k % 2 == 0) ? 13'd8 : 13'd9);
            step();
            check("rr cpu_resp", a_cpu_resp_valid, (k % 2 == 0) ? 1 : 0);
            check("rr dma_resp", a_dma_resp_valid, (k % 2 == 1) ? 1 : 0);
            check("rr dma_rdata", a_dma_resp_rdata | {31'h0, a_dma_resp_err}, 32'h0);
            step();
        end
        a_cpu_req_valid = 1'b0;

        // DMA load abandoned by reset during WAIT.
        a_dma_req_we = 1'b0; a_dma_req_addr = 32'h20;
        #1;
        check("rst_dma ready", a_dma_req_ready, 1);
        step();
        check("rst_dma issue", a_mem_en, 1);
        step();
        reset = 1'b1;
        #1;
        check("rst_dma mem_en", a_mem_en, 0);
        check("rst_dma resp", a_dma_resp_valid, 0);
        step();
        reset = 1'b0;
        a_cpu_req_valid = 1'b1; a_cpu_req_we = 1'b0; a_cpu_req_addr = 32'h20;
        #1;
        check("post_rst mem_en", a_mem_en, 0);
        check("post_rst dma_resp", a_dma_resp_valid, 0);
        check("post_rst cpu_ready", a_cpu_req_ready, 1);
        check("post_rst dma_ready", a_dma_req_ready, 0);
        step();
        a_cpu_req_valid = 1'b0;
        a_dma_req_valid = 1'b0;
        check("post_rst mem_addr", a_mem_addr, 13'd8);
        step();
        step();
        check("post_rst cpu_resp", a_cpu_resp_valid, 1);
        check("post_rst rdata", a_cpu_resp_rdata, 32'hC0C0_C0C0);
        check("post_rst dma quiet", a_dma_resp_valid, 0);
        step();

        // MEM_LAT=3: load at top word responds at T+5; one past the end faults.
        b_cpu_req_valid = 1'b1; b_cpu_req_addr = 32'h7FFC;
        #1;
        check("lat3 ready", b_cpu_req_ready, 1);
        step();
        b_cpu_req_valid = 1'b0;
        check("lat3 mem_en", b_mem_en, 1);
        check("lat3 mem_addr", b_mem_addr, 13'h1FFF);
        check("lat3 mem_be", b_mem_be, 4'b0000);
        check("lat3 mem_wdata", b_mem_wdata, 32'h0);
        step();
        step();
        step();
        check("lat3 T+4 resp", b_cpu_resp_valid, 0);
        step();
        check("lat3 T+5 resp", b_cpu_resp_valid, 1);
        check("lat3 rdata", b_cpu_resp_rdata, 32'hCAFE_F00D);
        check("lat3 err", b_cpu_resp_err, 0);
        check("lat3 dma quiet", b_dma_resp_valid | b_dma_req_ready | b_dma_resp_err, 0);
        check("lat3 dma rdata", b_dma_resp_rdata, 32'h0);
        step();
        b_cpu_req_valid = 1'b1; b_cpu_req_addr = 32'h8000;
        #1;
        check("oor ready", b_cpu_req_ready, 1);
        step();
        b_cpu_req_valid = 1'b0;
        check("oor mem_en", b_mem_en, 0);
        check("oor resp", b_cpu_resp_valid, 1);
        check("oor err", b_cpu_resp_err, 1);
        check("oor rdata", b_cpu_resp_rdata, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
